// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// operation select values and a small helper for picking the active done.
package muldiv_pkg;

  // Sequencer state encoding (also decoded by the main control unit).
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_ZEXC  = 3'd4;
  localparam logic [2:0] S_TOUT  = 3'd5;

  // Operation select: also drives the HI/LO source mux.
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Done pulse from the unit that was actually started; the other is ignored.
  function automatic logic sel_done(input logic op, input logic mult_done,
                                    input logic div_done);
    return (op == OP_DIV) ? div_done : mult_done;
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Watchdog counter for the WAIT state: clearable, enabled counter that
// raises a terminal-count flag at TIMEOUT-1 and saturates there.
module muldiv_watchdog #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Counter: clear on a new request, count while enabled, hold at terminal.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking = here would make results depend on block ordering.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/muldiv_sequencer.sv
// Control-side sequencer for the iterative multiply/divide units and the
// HI/LO registers. Starts the selected unit, waits for its done, then
// writes HI/LO and reports done, divide-by-zero or watchdog timeout.
// All outputs are a Moore decode of r_state and r_op_q.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic op_valid,
  input  logic op_sel,
  input  logic divisor_zero,
  input  logic abort,
  input  logic mult_done,
  input  logic div_done,
  output logic op_ready,
  output logic busy,
  output logic mult_start,
  output logic div_start,
  output logic hilo_src,
  output logic hi_write,
  output logic lo_write,
  output logic done,
  output logic div_zero_exc,
  output logic timeout_exc
);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic       r_op_q;
  logic       w_next_op_q;
  logic       w_accept;
  logic       w_tc;
  logic       w_sel_done;

  assign w_accept   = (r_state == S_IDLE) && op_valid;
  assign w_sel_done = sel_done(r_op_q, mult_done, div_done);

  muldiv_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .i_clr (w_accept),
    .i_en  (r_state == S_WAIT),
    .o_tc  (w_tc)
  );

  // Next-state and operation-latch logic.
  // NOTE: defaults at the top keep every path assigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_op_q  = r_op_q;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          if (op_sel == OP_DIV && divisor_zero) begin
            w_next_state = S_ZEXC;
            w_next_op_q  = OP_DIV;
          end else begin
            w_next_state = S_START;
            w_next_op_q  = op_sel;
          end
        end
      end
      S_START: w_next_state = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        // Abort beats done, and done beats timeout in the same cycle.
        if (abort)           w_next_state = S_IDLE;
        else if (w_sel_done) w_next_state = S_WRITE;
        else if (w_tc)       w_next_state = S_TOUT;
      end
      S_WRITE, S_ZEXC, S_TOUT: w_next_state = S_IDLE;
      default:                 w_next_state = S_IDLE;
    endcase
  end

  // State and operation registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op_q  <= OP_MULT;
    end else begin
      r_state <= w_next_state;
      r_op_q  <= w_next_op_q;
    end
  end

  // Moore output decode.
  always_comb begin
    op_ready     = (r_state == S_IDLE);
    busy         = (r_state != S_IDLE);
    mult_start   = (r_state == S_START) && (r_op_q == OP_MULT);
    div_start    = (r_state == S_START) && (r_op_q == OP_DIV);
    hilo_src     = r_op_q;
    hi_write     = (r_state == S_WRITE);
    lo_write     = (r_state == S_WRITE);
    done         = (r_state == S_WRITE) || (r_state == S_ZEXC) ||
                   (r_state == S_TOUT);
    div_zero_exc = (r_state == S_ZEXC);
    timeout_exc  = (r_state == S_TOUT);
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer. Each scenario steps cycle by cycle,
// cycle 0 being the cycle a request is presented, and compares every output
// against a hand-derived timeline at the falling edge.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clock;
  logic reset;
  logic op_valid, op_sel, divisor_zero, abort, mult_done, div_done;
  logic op_ready, busy, mult_start, div_start, hilo_src;
  logic hi_write, lo_write, done, div_zero_exc, timeout_exc;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sequencer #(.TIMEOUT(40)) dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_sel       (op_sel),
    .divisor_zero (divisor_zero),
    .abort        (abort),
    .mult_done    (mult_done),
    .div_done     (div_done),
    .op_ready     (op_ready),
    .busy         (busy),
    .mult_start   (mult_start),
    .div_start    (div_start),
    .hilo_src     (hilo_src),
    .hi_write     (hi_write),
    .lo_write     (lo_write),
    .done         (done),
    .div_zero_exc (div_zero_exc),
    .timeout_exc  (timeout_exc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output bundle: {ready,busy,mstart,dstart,src,hi_wr,lo_wr,done,zexc,texc}
  function automatic logic [9:0] obs();
    return {op_ready, busy, mult_start, div_start, hilo_src,
            hi_write, lo_write, done, div_zero_exc, timeout_exc};
  endfunction

  function automatic logic [9:0] ev(bit rdy, bit bsy, bit ms, bit ds, bit src,
                                    bit wr, bit dn, bit zx, bit tx);
    return {rdy, bsy, ms, ds, src, wr, wr, dn, zx, tx};
  endfunction

  task automatic check(input string tag, input logic [9:0] got,
                       input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(bit v, bit sel, bit dz, bit ab, bit md, bit dd);
    op_valid = v; op_sel = sel; divisor_zero = dz;
    abort = ab; mult_done = md; div_done = dd;
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge.
  task automatic sample(input string tag, input int c, input logic [9:0] exp);
    @(negedge clock);
    check($sformatf("%s c%0d", tag, c), obs(), exp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    sample("reset", 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    // MULT: done at 33, write at 34, ready at 35.
    for (int c = 0; c <= 36; c++) begin
      drive(c == 0, OP_MULT, 0, 0, c == 33, 0);
      sample("mult", c, ev(c == 0 || c >= 35, c >= 1 && c <= 34, c == 1, 0, 0,
                           c == 34, c == 34, 0, 0));
    end

    // DIV B!=0: spurious mult_done at 5 ignored, div_done at 10, write at 11.
    for (int c = 0; c <= 13; c++) begin
      drive(c == 0, OP_DIV, 0, 0, c == 5, c == 10);
      sample("div", c, ev(c == 0 || c >= 12, c >= 1 && c <= 11, 0, c == 1,
                          c >= 1, c == 11, c == 11, 0, 0));
    end

    // DIV B=0: exception at cycle 1, no start, no write.
    for (int c = 0; c <= 3; c++) begin
      drive(c == 0, OP_DIV, 1, 0, 0, 0);
      sample("divzero", c, ev(c != 1, c == 1, 0, 0, 1, 0, c == 1, c == 1, 0));
    end

    // Timeout: WAIT count 0..39 at cycles 2..41, TOUT at 42.
    // Non-selected div_done at 20 must be ignored.
    for (int c = 0; c <= 44; c++) begin
      drive(c == 0, OP_MULT, 0, 0, 0, c == 20);
      sample("tout", c, ev(c == 0 || c >= 43, c >= 1 && c <= 42, c == 1, 0,
                           c == 0, 0, c == 42, 0, c == 42));
    end

    // Abort at 5 in WAIT: IDLE at 6, div_done at 8 ignored.
    for (int c = 0; c <= 10; c++) begin
      drive(c == 0, OP_DIV, 0, c == 5, 0, c == 8);
      sample("abort", c, ev(c == 0 || c >= 6, c >= 1 && c <= 5, 0, c == 1,
                            c >= 1, 0, 0, 0, 0));
    end

    // Reset low at 4 (mid-WAIT): reset values at 5. New MULT at 6 with
    // abort high while IDLE (still accepted), done at 12, write at 13.
    for (int c = 0; c <= 15; c++) begin
      reset = (c == 4) ? 1'b0 : 1'b1;
      drive(c == 0 || c == 6, OP_MULT, 0, c == 6, c == 12, 0);
      sample("rst", c, ev(c == 0 || c == 5 || c == 6 || c >= 14,
                          (c >= 1 && c <= 4) || (c >= 7 && c <= 13),
                          c == 1 || c == 7, 0, c == 0, c == 13, c == 13, 0, 0));
    end
    reset = 1'b1;

    // Back-to-back at the minimum 4-cycle interval: MULT then DIV.
    for (int c = 0; c <= 9; c++) begin
      drive(c == 0 || c == 4, (c == 4) ? OP_DIV : OP_MULT, 0, 0, c == 2, c == 6);
      sample("b2b", c, ev(c == 0 || c == 4 || c >= 8,
                          (c >= 1 && c <= 3) || (c >= 5 && c <= 7),
                          c == 1, c == 5, c >= 5, c == 3 || c == 7,
                          c == 3 || c == 7, 0, 0));
    end

    // Done on the terminal-count cycle (41) wins over timeout: write at 42.
    for (int c = 0; c <= 44; c++) begin
      drive(c == 0, OP_MULT, 0, 0, c == 41, 0);
      sample("prio", c, ev(c == 0 || c >= 43, c >= 1 && c <= 42, c == 1, 0,
                           c == 0, c == 42, c == 42, 0, 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
